// File: rtl/clock_meter_pkg.sv
// clock_period_meter shared definitions.
// State encoding and default 100 MHz / 4 Hz build constants.
package clock_meter_pkg;

   typedef enum logic {
      WAIT_EDGE = 1'b0,
      MEASURE   = 1'b1
   } meter_state_t;

   localparam int CNT_W_DEF   = 27;
   localparam int EXPECT_DEF  = 25000000;
   localparam int TOL_DEF     = 250000;
   localparam int LOCK_N_DEF  = 4;
   localparam int TIMEOUT_DEF = 50000000;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with a history flop.
// Emits a one-cycle rise pulse for a slow asynchronous input.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic rise
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic hist_q, hist_d;

   // shift chain: metastability stages, then history
   always_comb begin
      sync1_d = d_in;
      sync2_d = sync1_q;
      hist_d  = sync2_q;
   end

   // synchronizer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         hist_q  <= hist_d;
      end
   end

   assign rise = sync2_q & ~hist_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period of a slow asynchronous clock in clk cycles.
// Reports period, tick enable, lock and loss-of-clock.
module clock_period_meter
   import clock_meter_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int EXPECT  = EXPECT_DEF,
   parameter int TOL     = TOL_DEF,
   parameter int LOCK_N  = LOCK_N_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_in,
   output logic             tick,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout
);

   localparam int GOOD_W = $clog2(LOCK_N + 1);
   localparam logic [CNT_W-1:0]  TMO_V  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0]    EXP_V  = (CNT_W + 1)'(EXPECT);
   localparam logic [CNT_W:0]    TOL_V  = (CNT_W + 1)'(TOL);
   localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_N);

   meter_state_t      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic              tick_q, tick_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic              pv_q, pv_d;
   logic              locked_q, locked_d;
   logic              timeout_q, timeout_d;

   logic              rise;
   logic              at_max;
   logic [CNT_W:0]    cnt_ext;
   logic [CNT_W:0]    diff;
   logic              in_tol;

   sync_edge_detect u_sync (
      .clk  (clk),
      .rst  (rst),
      .d_in (clk_in),
      .rise (rise)
   );

   assign at_max = (cnt_q == TMO_V);

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= WAIT_EDGE;
         cnt_q     <= '0;
         good_q    <= '0;
         tick_q    <= 1'b0;
         period_q  <= '0;
         pv_q      <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         good_q    <= good_d;
         tick_q    <= tick_d;
         period_q  <= period_d;
         pv_q      <= pv_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   // next state: an edge always starts/continues a measurement
   always_comb begin
      state_d = state_q;
      if (rise) begin
         state_d = MEASURE;
      end else if (at_max) begin
         state_d = WAIT_EDGE;
      end
   end

   // counter, period capture, lock and timeout; rise beats timeout
   always_comb begin
      cnt_ext   = {1'b0, cnt_q};
      diff      = (cnt_ext >= EXP_V) ? (cnt_ext - EXP_V)
                                     : (EXP_V - cnt_ext);
      in_tol    = (diff <= TOL_V);
      cnt_d     = at_max ? cnt_q : cnt_q + CNT_W'(1);
      good_d    = good_q;
      tick_d    = 1'b0;
      period_d  = period_q;
      pv_d      = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;
      if (rise) begin
         tick_d    = 1'b1;
         cnt_d     = CNT_W'(1);
         timeout_d = 1'b0;
         if (state_q == MEASURE) begin
            pv_d     = 1'b1;
            period_d = cnt_q;
            if (in_tol) begin
               if (good_q != LOCK_V) begin
                  good_d = good_q + GOOD_W'(1);
               end
               locked_d = (good_d == LOCK_V);
            end else begin
               good_d   = '0;
               locked_d = 1'b0;
            end
         end
      end else if (at_max) begin
         timeout_d = 1'b1;
         locked_d  = 1'b0;
         good_d    = '0;
      end
   end

   assign tick         = tick_q;
   assign period       = period_q;
   assign period_valid = pv_q;
   assign locked       = locked_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter.
// Edge-event reference model, directed plus randomized waveforms.
module tb_clock_period_meter;

   localparam int CNT_W   = 8;
   localparam int EXPECT  = 20;
   localparam int TOL     = 2;
   localparam int LOCK_N  = 3;
   localparam int TIMEOUT = 40;

   logic             clk;
   logic             rst;
   logic             clk_in;
   logic             tick;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             locked;
   logic             timeout;

   int total;
   int bad;

   int edge_n;
   int ref_n;
   int good;
   bit measuring;
   bit prev_ci;
   int evq[$];

   logic             e_tick;
   logic [CNT_W-1:0] e_period;
   logic             e_pv;
   logic             e_locked;
   logic             e_timeout;

   clock_period_meter #(
      .CNT_W   (CNT_W),
      .EXPECT  (EXPECT),
      .TOL     (TOL),
      .LOCK_N  (LOCK_N),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clk_in       (clk_in),
      .tick         (tick),
      .period       (period),
      .period_valid (period_valid),
      .locked       (locked),
      .timeout      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A rise of clk_in seen at edge s produces tick at edge s+2.
   // Period = distance between tick edges; timeout 40 edges after
   // the last tick (or 41 edges after the last reset edge).
   task automatic model_edge(input logic r);
      int gap;
      e_tick = 1'b0;
      e_pv   = 1'b0;
      if (r) begin
         e_period  = '0;
         e_locked  = 1'b0;
         e_timeout = 1'b0;
         good      = 0;
         measuring = 1'b0;
         ref_n     = edge_n + 1;
         evq.delete();
      end else if (evq.size() != 0 && evq[0] == edge_n) begin
         void'(evq.pop_front());
         e_tick    = 1'b1;
         e_timeout = 1'b0;
         if (measuring) begin
            gap      = edge_n - ref_n;
            e_period = CNT_W'(gap);
            e_pv     = 1'b1;
            if (gap >= EXPECT - TOL && gap <= EXPECT + TOL) begin
               if (good < LOCK_N) good++;
            end else begin
               good = 0;
            end
            e_locked = (good == LOCK_N);
         end
         measuring = 1'b1;
         ref_n     = edge_n;
      end else if (edge_n - ref_n == TIMEOUT) begin
         e_timeout = 1'b1;
         e_locked  = 1'b0;
         good      = 0;
         measuring = 1'b0;
      end
   endtask

   task automatic check_all();
      total++;
      assert (tick === e_tick) else begin
         bad++;
         $error("FAIL tick edge=%0d obs=%b exp=%b",
                edge_n, tick, e_tick);
      end
      total++;
      assert (period_valid === e_pv) else begin
         bad++;
         $error("FAIL period_valid edge=%0d obs=%b exp=%b",
                edge_n, period_valid, e_pv);
      end
      total++;
      assert (period === e_period) else begin
         bad++;
         $error("FAIL period edge=%0d obs=%0d exp=%0d",
                edge_n, period, e_period);
      end
      total++;
      assert (locked === e_locked) else begin
         bad++;
         $error("FAIL locked edge=%0d obs=%b exp=%b",
                edge_n, locked, e_locked);
      end
      total++;
      assert (timeout === e_timeout) else begin
         bad++;
         $error("FAIL timeout edge=%0d obs=%b exp=%b",
                edge_n, timeout, e_timeout);
      end
   endtask

   // drive inputs mid-cycle, then check just after the next edge
   task automatic cyc(input logic ci, input logic r);
      @(negedge clk);
      clk_in = ci;
      rst    = r;
      if (ci && !prev_ci) evq.push_back(edge_n + 3);
      prev_ci = ci;
      @(posedge clk);
      edge_n++;
      #1;
      model_edge(r);
      check_all();
   endtask

   task automatic wave(input int hi, input int lo);
      for (int i = 0; i < hi; i++) cyc(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) cyc(1'b0, 1'b0);
   endtask

   task automatic waves20(input int n);
      for (int i = 0; i < n; i++) wave(10, 10);
   endtask

   initial begin
      int p;
      int h;
      total     = 0;
      bad       = 0;
      edge_n    = 0;
      ref_n     = 0;
      good      = 0;
      measuring = 1'b0;
      prev_ci   = 1'b0;
      rst       = 1'b1;
      clk_in    = 1'b0;

      // reset with clk_in toggling
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);

      // nominal 20-cycle input, lock on third period
      waves20(5);

      // tolerance boundaries, then drop and relock
      wave(9, 9);
      wave(11, 11);
      wave(12, 11);
      waves20(4);

      // randomized periods around nominal
      for (int i = 0; i < 16; i++) begin
         p = int'($urandom_range(17, 23));
         h = p / 2;
         wave(h, p - h);
      end

      // loss of clock after lock, then restart
      waves20(4);
      for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
      waves20(5);

      // period exactly at the timeout boundary
      for (int i = 0; i < 3; i++) wave(20, 20);
      waves20(4);

      // randomized periods straddling the timeout boundary
      for (int i = 0; i < 10; i++) begin
         p = int'($urandom_range(38, 42));
         h = int'($urandom_range(2, 20));
         wave(h, p - h);
      end
      waves20(4);

      // reset mid-measurement while locked
      wave(10, 3);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
      waves20(4);

      // randomized duty and period
      for (int i = 0; i < 12; i++) begin
         h = int'($urandom_range(2, 12));
         p = int'($urandom_range(2, 14));
         wave(h, p);
      end
      for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
